// File: rtl/narrower32_16.sv
// narrower32_16: splits 32-bit words into one compressed or two raw halfword beats with saturating stats
module narrower32_16 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in,
  input  logic             sign_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out,
  output logic             out_ext,
  output logic             out_fits,
  output logic             out_last,
  output logic [CNT_W-1:0] fit_cnt,
  output logic [CNT_W-1:0] split_cnt
);
  typedef enum logic [1:0] {IDLE, ONE, LOW, HIGH} state_t;
  state_t state, nxt;
  logic [31:0] word;
  logic ext, fits;
  logic ext_in, fits_in;
  assign ext_in  = sign_mode & in[15];
  assign fits_in = in[31:16] == {16{ext_in}};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word <= '0;
      ext  <= 1'b0;
      fits <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      word <= in;
      ext  <= ext_in;
      fits <= fits_in;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fit_cnt   <= '0;
      split_cnt <= '0;
    end else begin
      if (state == ONE && out_ready && fit_cnt != '1) fit_cnt <= fit_cnt + 1'b1;
      if (state == HIGH && out_ready && split_cnt != '1) split_cnt <= split_cnt + 1'b1;
    end
  // Outputs decode only registered state, so there is no input-to-output path
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out       = '0;
    out_ext   = 1'b0;
    out_fits  = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        nxt      = in_valid ? (fits_in ? ONE : LOW) : IDLE;
      end
      ONE: begin
        out_valid = 1'b1;
        out       = word[15:0];
        out_ext   = ext;
        out_fits  = fits;
        out_last  = 1'b1;
        nxt       = out_ready ? IDLE : ONE;
      end
      LOW: begin
        out_valid = 1'b1;
        out       = word[15:0];
        nxt       = out_ready ? HIGH : LOW;
      end
      default: begin
        out_valid = 1'b1;
        out       = word[31:16];
        out_last  = 1'b1;
        nxt       = out_ready ? IDLE : HIGH;
      end
    endcase
  end
endmodule

// File: tb/tb_narrower32_16.sv
// tb_narrower32_16: directed-vector bench for narrower32_16 (default and CNT_W=2 instances)
module tb_narrower32_16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [31:0] in = '0;
  logic sign_mode = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_ext, out_fits, out_last;
  logic [15:0] out, fit_cnt, split_cnt;
  logic in_ready2, out_valid2, out_ext2, out_fits2, out_last2;
  logic [15:0] out2;
  logic [1:0] fit_cnt2, split_cnt2;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  narrower32_16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .sign_mode(sign_mode), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_ext(out_ext), .out_fits(out_fits), .out_last(out_last),
    .fit_cnt(fit_cnt), .split_cnt(split_cnt)
  );
  narrower32_16 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in(in),
    .sign_mode(sign_mode), .out_valid(out_valid2), .out_ready(out_ready), .out(out2),
    .out_ext(out_ext2), .out_fits(out_fits2), .out_last(out_last2),
    .fit_cnt(fit_cnt2), .split_cnt(split_cnt2)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic accept(input logic [31:0] w, input logic sm);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in = w;
    sign_mode = sm;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    sign_mode = ~sm;
    in = 32'hDEADBEEF;
  endtask
  task automatic beat(input string tag, input logic [15:0] o, input logic e, input logic f, input logic l);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_out"}, out, o);
    check({tag, "_ext"}, out_ext, e);
    check({tag, "_fits"}, out_fits, f);
    check({tag, "_last"}, out_last, l);
    check({tag, "_in_ready"}, in_ready, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_flags", {out_ext, out_fits, out_last}, 0);
    check("rst_cnts", {fit_cnt, split_cnt}, 0);
    @(negedge clk) rst = 1'b0;
    accept(32'hFFFF8000, 1'b1);
    beat("sgn_fit", 16'h8000, 1, 1, 1);
    check("fit_cnt_1", fit_cnt, 1);
    check("split_cnt_0", split_cnt, 0);
    accept(32'hFFFF8000, 1'b0);
    beat("zero_lo", 16'h8000, 0, 0, 0);
    beat("zero_hi", 16'hFFFF, 0, 0, 1);
    check("split_cnt_1", split_cnt, 1);
    accept(32'h00001234, 1'b0);
    beat("zero_fit", 16'h1234, 0, 1, 1);
    accept(32'h00007FFF, 1'b1);
    beat("sgn_pos", 16'h7FFF, 0, 1, 1);
    accept(32'h0000FFFF, 1'b1);
    beat("sgn_bad_lo", 16'hFFFF, 0, 0, 0);
    beat("sgn_bad_hi", 16'h0000, 0, 0, 1);
    check("fit_cnt_3", fit_cnt, 3);
    check("split_cnt_2", split_cnt, 2);
    out_ready = 1'b0;
    accept(32'h12345678, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_out", out, 16'h5678);
      check("bp_last", out_last, 0);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hi_pending", out, 16'h1234);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_cnts", {fit_cnt, split_cnt}, 0);
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", out_valid, 0);
      check("post_rst_in_ready", in_ready, 1);
    end
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      accept(32'h00000001, 1'b0);
      beat("sat_beat", 16'h0001, 0, 1, 1);
      check("sat_cnt2", fit_cnt2, (i > 3) ? 3 : i);
      check("sat_cnt16", fit_cnt, i);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
